// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side character buffer placed after the UART receiver.
// Captures each character on a one-cycle write strobe into a circular buffer.
// The host drains the buffer through a read port with one cycle of latency.
//
// Ports:
//   sys_clk      - system clock, all state updates on the rising edge
//   rst          - asynchronous active-low reset
//   wr_data      - character from the receiver
//   wr_valid     - one-cycle strobe, wr_data holds a new character
//   rd_en        - host read request
//   rd_data      - registered read data, holds its value between reads
//   rd_valid     - one-cycle pulse, rd_data holds a newly popped character
//   count        - number of stored entries, 0..DEPTH
//   empty        - count == 0
//   full         - count == DEPTH
//   almost_full  - count >= AF_LEVEL
//   overflow     - sticky, set when a character was dropped
//   overflow_clr - clears overflow; a drop in the same cycle takes priority
module uart_rx_fifo #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_LEVEL  = 12
) (
   input  logic                     sys_clk,
   input  logic                     rst,
   input  logic [DATA_BITS-1:0]     wr_data,
   input  logic                     wr_valid,
   input  logic                     rd_en,
   output logic [DATA_BITS-1:0]     rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_full,
   output logic                     overflow,
   input  logic                     overflow_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
   localparam logic [CW-1:0] AfCnt   = CW'(AF_LEVEL);

   logic [DATA_BITS-1:0] mem_q [DEPTH];

   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 overflow_q, overflow_d;

   logic rd_acc;
   logic wr_acc;
   logic wr_drop;

   // Flags decode the registered count, so they lag an operation by one edge.
   assign empty       = (count_q == '0);
   assign full        = (count_q == FullCnt);
   assign almost_full = (count_q >= AfCnt);

   always_comb begin
      rd_acc  = rd_en & ~empty;
      // A read in the same cycle frees a slot, so a write to a full buffer still fits.
      wr_acc  = wr_valid & (~full | rd_acc);
      wr_drop = wr_valid & ~wr_acc;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      overflow_d = overflow_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + AW'(1);
         rd_data_d  = mem_q[rd_ptr_q];
         rd_valid_d = 1'b1;
      end

      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Set wins over clear.
      if (wr_drop) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage carries no reset; stale contents are unreachable once pointers clear.
   always_ff @(posedge sys_clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the buffer.
module tb_uart_rx_fifo;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned DEPTH     = 16;
   localparam int unsigned AF_LEVEL  = 12;
   localparam int unsigned CW        = $clog2(DEPTH) + 1;
   localparam int unsigned OW        = 1 + DATA_BITS + CW + 4;

   logic                 sys_clk = 1'b0;
   logic                 rst = 1'b0;
   logic [DATA_BITS-1:0] wr_data = '0;
   logic                 wr_valid = 1'b0;
   logic                 rd_en = 1'b0;
   logic [DATA_BITS-1:0] rd_data;
   logic                 rd_valid;
   logic [CW-1:0]        count;
   logic                 empty;
   logic                 full;
   logic                 almost_full;
   logic                 overflow;
   logic                 overflow_clr = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   uart_rx_fifo #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (DEPTH),
      .AF_LEVEL  (AF_LEVEL)
   ) dut (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .wr_data      (wr_data),
      .wr_valid     (wr_valid),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference model: contents as a queue, plus last read result and sticky flag.
   logic [DATA_BITS-1:0] m_q[$];
   logic [DATA_BITS-1:0] m_rd_data;
   logic                 m_rd_valid;
   logic                 m_ovf;

   logic [OW-1:0] obs;
   assign obs = {rd_valid, rd_data, count, empty, full, almost_full, overflow};

   function automatic logic [OW-1:0] model_outs();
      int n;
      n = m_q.size();
      return {m_rd_valid, m_rd_data, CW'(n), n == 0, n == int'(DEPTH),
              n >= int'(AF_LEVEL), m_ovf};
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
   endtask

   // One clock: drive inputs, advance the model at the edge, return 1 time unit after it.
   task automatic step(input logic wv, input logic [DATA_BITS-1:0] wd, input logic re,
                       input logic oc);
      logic racc;
      logic wacc;
      wr_valid     = wv;
      wr_data      = wd;
      rd_en        = re;
      overflow_clr = oc;
      @(posedge sys_clk);
      racc = re && (m_q.size() != 0);
      wacc = wv && ((m_q.size() < int'(DEPTH)) || racc);
      m_rd_valid = racc;
      if (racc) m_rd_data = m_q.pop_front();
      if (wacc) m_q.push_back(wd);
      if (wv && !wacc) m_ovf = 1'b1;
      else if (oc) m_ovf = 1'b0;
      #1;
      wr_valid     = 1'b0;
      rd_en        = 1'b0;
      overflow_clr = 1'b0;
   endtask

   task automatic test_reset();
      logic [OW-1:0] exp;
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge sys_clk);
      #1;
      exp = {1'b0, 8'h00, CW'(0), 1'b1, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp) $display("FAIL reset_state: got %h expected %h", obs, exp);
      else n_pass++;
      rst = 1'b1;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic test_basic();
      logic [DATA_BITS-1:0] bytes [3];
      bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, bytes[i], 1'b0, 1'b0);
         n_checks++;
         if (obs !== model_outs() || count !== CW'(i + 1))
            $display("FAIL basic_write%0d: got %h expected %h", i, obs, model_outs());
         else n_pass++;
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         n_checks++;
         if (obs !== model_outs() || rd_data !== bytes[i] || rd_valid !== 1'b1)
            $display("FAIL basic_read%0d: got %h expected %h", i, obs, model_outs());
         else n_pass++;
      end
      step(1'b0, '0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== model_outs() || empty !== 1'b1)
         $display("FAIL basic_drained: got %h expected %h", obs, model_outs());
      else n_pass++;
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < int'(DEPTH); i++) begin
         step(1'b1, DATA_BITS'(i), 1'b0, 1'b0);
         n_checks++;
         if (obs !== model_outs() || almost_full !== (i + 1 >= int'(AF_LEVEL)))
            $display("FAIL fill%0d: got %h expected %h", i, obs, model_outs());
         else n_pass++;
      end
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      n_checks++;
      if (obs !== model_outs() || overflow !== 1'b1 || count !== CW'(DEPTH))
         $display("FAIL overflow_drop: got %h expected %h", obs, model_outs());
      else n_pass++;
      for (int i = 0; i < int'(DEPTH); i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         n_checks++;
         if (obs !== model_outs() || rd_data !== DATA_BITS'(i))
            $display("FAIL drain%0d: got %h expected %h", i, obs, model_outs());
         else n_pass++;
      end
   endtask

   task automatic test_full_simul();
      logic [DATA_BITS-1:0] oldest;
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < int'(DEPTH); i++) step(1'b1, DATA_BITS'($urandom), 1'b0, 1'b0);
      oldest = m_q[0];
      step(1'b1, 8'h55, 1'b1, 1'b0);
      n_checks++;
      if (obs !== model_outs() || rd_data !== oldest || overflow !== 1'b0)
         $display("FAIL full_rw: got %h expected %h", obs, model_outs());
      else n_pass++;
      for (int i = 0; i < int'(DEPTH); i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         n_checks++;
         if (obs !== model_outs())
            $display("FAIL full_rw_drain%0d: got %h expected %h", i, obs, model_outs());
         else n_pass++;
      end
      n_checks++;
      if (rd_data !== 8'h55) $display("FAIL full_rw_last: got %h expected 55", rd_data);
      else n_pass++;
   endtask

   task automatic test_empty_simul();
      step(1'b1, 8'h7E, 1'b1, 1'b0);
      n_checks++;
      if (obs !== model_outs() || rd_valid !== 1'b0 || count !== CW'(1))
         $display("FAIL empty_rw: got %h expected %h", obs, model_outs());
      else n_pass++;
      step(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (obs !== model_outs() || rd_data !== 8'h7E || rd_valid !== 1'b1)
         $display("FAIL empty_rw_read: got %h expected %h", obs, model_outs());
      else n_pass++;
   endtask

   task automatic test_overflow_clr();
      for (int i = 0; i < int'(DEPTH) + 1; i++) step(1'b1, DATA_BITS'($urandom), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      n_checks++;
      if (obs !== model_outs() || overflow !== 1'b1)
         $display("FAIL ovf_set_wins: got %h expected %h", obs, model_outs());
      else n_pass++;
      step(1'b0, '0, 1'b0, 1'b1);
      n_checks++;
      if (obs !== model_outs() || overflow !== 1'b0)
         $display("FAIL ovf_clear: got %h expected %h", obs, model_outs());
      else n_pass++;
      for (int i = 0; i < int'(DEPTH); i++) step(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (obs !== model_outs()) $display("FAIL ovf_drain: got %h expected %h", obs, model_outs());
      else n_pass++;
   endtask

   task automatic test_wrap_reset();
      int errs;
      logic [OW-1:0] exp_rst;
      errs = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, DATA_BITS'($urandom), i >= 3, 1'b0);
         n_checks++;
         if (obs !== model_outs())
            $display("FAIL wrap%0d: got %h expected %h", i, obs, model_outs());
         else n_pass++;
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b1, DATA_BITS'($urandom), 1'b1, 1'b0);
      end
      // Mid-cycle asynchronous reset, checked before any clock edge.
      #2;
      wr_valid = 1'b1;
      rd_en    = 1'b1;
      rst      = 1'b0;
      model_reset();
      #1;
      exp_rst = {1'b0, rd_data, CW'(0), 1'b1, 1'b0, 1'b0, 1'b0};
      n_checks++;
      if (count !== CW'(0) || empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h00
          || overflow !== 1'b0)
         $display("FAIL async_reset: got %h expected %h", obs, exp_rst);
      else n_pass++;
      wr_valid = 1'b0;
      rd_en    = 1'b0;
      @(posedge sys_clk);
      #1;
      rst = 1'b1;
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (obs !== model_outs() || rd_data !== 8'h11 || rd_valid !== 1'b1)
         $display("FAIL post_reset_rw: got %h expected %h", obs, model_outs());
      else n_pass++;
      errs = errs;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 55, DATA_BITS'($urandom), $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 10);
         n_checks++;
         if (obs !== model_outs())
            $display("FAIL random%0d: got %h expected %h", i, obs, model_outs());
         else n_pass++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_fill_overflow();
      test_full_simul();
      test_empty_simul();
      test_overflow_clr();
      test_wrap_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
